// File: rtl/oled_digit_writer.sv
// oled_digit_writer: AHB-Lite slave takes a binary value and a layout, converts it to BCD, then masters digit-code writes
// into oled_manager block slots. Optional LEADING_ZERO_BLANK_EN writes leading zeros as the empty code 12.
module oled_digit_writer #(
    parameter logic [31:0] OLED_BASE = 32'h5000_0000,
    parameter int VALUE_W = 16,
    parameter int MAX_DIGITS = 5
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic        HREADY,
    input  logic        HWRITE,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic [31:0] M_HADDR,
    output logic [1:0]  M_HTRANS,
    output logic        M_HWRITE,
    output logic [2:0]  M_HSIZE,
    output logic [31:0] M_HWDATA,
    input  logic        M_HREADY
);
    localparam int BW = 4 * MAX_DIGITS;
    localparam int CW = $clog2(VALUE_W);
    localparam logic [2:0] MAXD = 3'(MAX_DIGITS);
    typedef enum logic [1:0] {IDLE, CONV, WRITE, LAST} state_t;
    state_t state, state_nx;
    logic ph_wr, ph_rd, acc, ctrl_wr, val_wr, st_rd, accept, busy, ovf, drop, hi_nz;
    logic [1:0] ph_idx;
    logic [2:0] req_n, n, i, didx;
    logic [4:0] start, blk, code, data_q;
    logic [3:0] digit;
    logic [CW-1:0] cnt;
    logic [VALUE_W-1:0] value, bin;
    logic [BW-1:0] bcd, bcd_adj;
    logic unused_ok;
    assign acc = HSEL & HREADY & (HTRANS != 2'b00);
    assign ctrl_wr = ph_wr && ph_idx == 2'd1;
    assign val_wr = ph_wr && ph_idx == 2'd0;
    assign st_rd = ph_rd && ph_idx == 2'd2;
    assign req_n = HWDATA[7:5];
    assign busy = state != IDLE;
    assign accept = ctrl_wr && !busy && req_n != 3'd0 && req_n <= MAXD;
    assign didx = n - 3'd1 - i;
    assign digit = bcd[{didx, 2'b00} +: 4];
    assign blk = start + {2'b00, i};
    assign unused_ok = ^{HSIZE, HADDR, HWDATA};
    assign HREADYOUT = 1'b1;
    assign M_HSIZE = 3'b010;
    assign M_HTRANS = state == WRITE ? 2'b10 : 2'b00;
    assign M_HWRITE = state == WRITE;
    assign M_HADDR = state == WRITE ? OLED_BASE + {24'd0, 6'd4 + {1'b0, blk}, 2'b00} : 32'd0;
    assign M_HWDATA = {27'd0, data_q};
    assign HRDATA = !ph_rd ? 32'd0 : ph_idx == 2'd0 ? 32'(value) :
                    ph_idx == 2'd2 ? {29'd0, drop, ovf, busy} : 32'd0;
`ifdef LEADING_ZERO_BLANK_EN
    logic lead;
    always_ff @(posedge HCLK or negedge HRESETn)
        if (!HRESETn) lead <= 1'b1;
        else if (state != WRITE) lead <= 1'b1;
        else if (M_HREADY) lead <= lead & (digit == 4'd0);
    assign code = (lead && digit == 4'd0 && i != n - 3'd1) ? 5'd12 : {1'b0, digit};
`else
    assign code = {1'b0, digit};
`endif
    // nibble add-3 for double-dabble; digits above the requested count flag overflow
    always_comb begin
        bcd_adj = bcd;
        hi_nz = 1'b0;
        for (int k = 0; k < MAX_DIGITS; k++) begin
            if (bcd[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
            if (k >= int'(n) && bcd[4*k +: 4] != 4'd0) hi_nz = 1'b1;
        end
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  state_nx = accept ? CONV : IDLE;
            CONV:  state_nx = cnt == CW'(VALUE_W - 1) ? WRITE : CONV;
            WRITE: state_nx = (M_HREADY && i == n - 3'd1) ? LAST : WRITE;
            LAST:  state_nx = M_HREADY ? IDLE : LAST;
        endcase
    end
    always_ff @(posedge HCLK or negedge HRESETn)
        if (!HRESETn) begin
            state <= IDLE;
            ph_wr <= 1'b0;
            ph_rd <= 1'b0;
            ph_idx <= 2'd0;
            value <= '0;
            bin <= '0;
            bcd <= '0;
            cnt <= '0;
            start <= 5'd0;
            n <= 3'd0;
            i <= 3'd0;
            ovf <= 1'b0;
            drop <= 1'b0;
            data_q <= 5'd0;
        end else begin
            state <= state_nx;
            ph_wr <= acc & HWRITE;
            ph_rd <= acc & ~HWRITE;
            ph_idx <= HADDR[3:2];
            drop <= (drop & ~st_rd) | (ctrl_wr & busy);
            if (val_wr) value <= HWDATA[VALUE_W-1:0];
            if (accept) begin
                start <= HWDATA[4:0];
                n <= req_n;
                bin <= value;
                bcd <= '0;
                cnt <= '0;
                i <= 3'd0;
                ovf <= 1'b0;
            end
            if (state == CONV) begin
                bcd <= {bcd_adj[BW-2:0], bin[VALUE_W-1]};
                bin <= bin << 1;
                cnt <= cnt + 1'b1;
            end
            if (state == WRITE) ovf <= ovf | hi_nz;
            if (state == WRITE && M_HREADY) begin
                data_q <= code;
                i <= i + 3'd1;
            end
        end
endmodule

// File: tb/tb_oled_digit_writer.sv
// tb_oled_digit_writer: directed and randomized jobs checked against an arithmetic decimal model
// plus a passive AHB master-side monitor.
module tb_oled_digit_writer;
    localparam logic [31:0] BASE = 32'h5000_0000;
    localparam int VW = 16;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif
    logic HCLK = 1'b0, HRESETn = 1'b0, HSEL = 1'b0, HREADY = 1'b1, HWRITE = 1'b0, M_HREADY = 1'b1;
    logic [31:0] HADDR = 32'd0, HWDATA = 32'd0;
    logic [2:0] HSIZE = 3'b010;
    logic [1:0] HTRANS = 2'b00;
    logic [31:0] HRDATA, M_HADDR, M_HWDATA;
    logic HREADYOUT, M_HWRITE;
    logic [1:0] M_HTRANS;
    logic [2:0] M_HSIZE;
    int tests = 0, fails = 0, cyc = 0, ns_cyc = -1, tcyc = 0;
    bit rnd_mode = 1'b0, stall_req = 1'b0, dp_valid = 1'b0, st_v = 1'b0;
    logic [31:0] got_a[$], got_d[$];
    logic [31:0] dp_addr, st_a, st_d;
    logic [1:0] st_t;

    oled_digit_writer dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY), .HWRITE(HWRITE),
        .HADDR(HADDR), .HWDATA(HWDATA), .HSIZE(HSIZE), .HTRANS(HTRANS), .HRDATA(HRDATA),
        .HREADYOUT(HREADYOUT), .M_HADDR(M_HADDR), .M_HTRANS(M_HTRANS), .M_HWRITE(M_HWRITE),
        .M_HSIZE(M_HSIZE), .M_HWDATA(M_HWDATA), .M_HREADY(M_HREADY)
    );

    always #5 HCLK = ~HCLK;
    always @(posedge HCLK) cyc <= cyc + 1;
    always @(posedge HCLK) begin
        #2;
        M_HREADY = rnd_mode ? ($urandom_range(0, 2) != 0) : !stall_req;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // passive AHB slave view of the master port: captures completed writes, checks stall holding
    always @(negedge HCLK) begin
        if (!HRESETn) begin
            dp_valid = 1'b0;
            st_v = 1'b0;
        end else begin
            if (st_v) begin
                check("hold_addr", M_HADDR, st_a);
                check("hold_trans", {30'd0, M_HTRANS}, {30'd0, st_t});
                check("hold_data", M_HWDATA, st_d);
            end
            st_v = !M_HREADY && (M_HTRANS == 2'b10 || dp_valid);
            st_a = M_HADDR;
            st_t = M_HTRANS;
            st_d = M_HWDATA;
            if (M_HTRANS == 2'b10) begin
                check("m_size_write", {28'd0, M_HSIZE, M_HWRITE}, 32'h5);
                if (ns_cyc < 0) ns_cyc = cyc;
            end
            if (dp_valid && M_HREADY) begin
                got_a.push_back(dp_addr);
                got_d.push_back(M_HWDATA);
            end
            if (M_HREADY) begin
                dp_valid = M_HTRANS == 2'b10;
                dp_addr = M_HADDR;
            end
        end
    end

    task automatic cycles(input int k);
        repeat (k) begin
            @(posedge HCLK);
            #1;
        end
    endtask

    task automatic ahb_write(input logic [1:0] idx, input logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {28'd0, idx, 2'b00};
        cycles(1);
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
        cycles(1);
    endtask

    task automatic ahb_read(input logic [1:0] idx, output logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {28'd0, idx, 2'b00};
        cycles(1);
        HSEL = 1'b0; HTRANS = 2'b00;
        d = HRDATA;
        cycles(1);
    endtask

    task automatic read_status2(output logic [31:0] s1, output logic [31:0] s2);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h8;
        cycles(1);
        s1 = HRDATA;
        cycles(1);
        s2 = HRDATA;
        HSEL = 1'b0; HTRANS = 2'b00;
    endtask

    task automatic start_job(input int v, input int s, input int n);
        got_a.delete();
        got_d.delete();
        ns_cyc = -1;
        ahb_write(2'd0, 32'(v));
        ahb_write(2'd1, {24'd0, 3'(n), 5'(s)});
        tcyc = cyc;
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] s;
        int k;
        for (k = 0; k < 100; k++) begin
            ahb_read(2'd2, s);
            if (!s[0]) break;
        end
        check({tag, "_idle"}, 32'(k < 100), 32'd1);
    endtask

    task automatic check_writes(input int v, input int s, input int n, input string tag);
        longint p;
        bit lead;
        int d, c;
        logic [31:0] st;
        p = 1;
        lead = 1'b1;
        for (int k = 0; k < n; k++) p = p * 10;
        check({tag, "_cnt"}, 32'(got_a.size()), 32'(n));
        for (int k = 0; k < n; k++) begin
            p = p / 10;
            d = int'((longint'(v) / p) % 10);
            c = (LZB && lead && d == 0 && k != n - 1) ? 12 : d;
            if (d != 0) lead = 1'b0;
            if (k < got_a.size()) begin
                check({tag, "_addr"}, got_a[k], BASE + 32'((4 + ((s + k) % 32)) * 4));
                check({tag, "_code"}, got_d[k], 32'(c));
            end
        end
        p = 1;
        for (int k = 0; k < n; k++) p = p * 10;
        ahb_read(2'd2, st);
        check({tag, "_status"}, st, {30'd0, longint'(v) >= p, 1'b0});
    endtask

    task automatic run_job(input int v, input int s, input int n, input string tag);
        start_job(v, s, n);
        wait_idle(tag);
        check_writes(v, s, n, tag);
    endtask

    initial begin
        logic [31:0] s1, s2;
        int v, st, n;
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] s1, s2;
        int v, st, n;
        cycles(3);
        check("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        check("rst_msize", {29'd0, M_HSIZE}, 32'd2);
        check("rst_mtrans", {30'd0, M_HTRANS}, 32'd0);
        check("rst_maddr", M_HADDR, 32'd0);
        check("rst_mwdata", M_HWDATA, 32'd0);
        check("rst_hrdata", HRDATA, 32'd0);
        HRESETn = 1'b1;
        cycles(1);
        ahb_read(2'd2, s1);
        check("rst_status", s1, 32'd0);
        ahb_read(2'd0, s1);
        check("rst_value", s1, 32'd0);

        start_job(1234, 9, 4);
        cycles(VW + 4 - 1);
        read_status2(s1, s2);
        check("lat_busy_last", {31'd0, s1[0]}, 32'd1);
        check("lat_busy_done", {31'd0, s2[0]}, 32'd0);
        check("lat_first_nonseq", 32'(ns_cyc), 32'(tcyc + VW));
        cycles(1);
        check_writes(1234, 9, 4, "j1234");

        run_job(65535, 0, 5, "j65535");
        run_job(1000, 2, 3, "jovf");
        start_job(42, 5, 2);
        ahb_read(2'd2, s1);
        check("ovf_clr_accept", s1, 32'd1);
        wait_idle("j42");
        check_writes(42, 5, 2, "j42");
        run_job(7, 30, 4, "jwrap");

        start_job(4321, 12, 4);
        cycles(VW + 1);
        stall_req = 1'b1;
        cycles(3);
        stall_req = 1'b0;
        wait_idle("jstall");
        check_writes(4321, 12, 4, "jstall");

        start_job(56789, 3, 5);
        ahb_write(2'd1, {24'd0, 3'd2, 5'd7});
        ahb_write(2'd0, 32'd111);
        ahb_read(2'd2, s1);
        check("drop_set", s1 & 32'h5, 32'h5);
        ahb_read(2'd2, s1);
        check("drop_clr", s1 & 32'h4, 32'h0);
        wait_idle("jdrop");
        check_writes(56789, 3, 5, "jdrop");
        ahb_read(2'd0, s1);
        check("value_new", s1, 32'd111);

        got_a.delete();
        got_d.delete();
        for (int k = 0; k < 3; k++) begin
            n = (k == 0) ? 0 : 5 + k;
            ahb_write(2'd1, {24'd0, 3'(n), 5'd1});
            ahb_read(2'd2, s1);
            check("bad_n_idle", s1 & 32'h1, 32'h0);
        end
        cycles(VW + 8);
        check("bad_n_nowrites", 32'(got_a.size()), 32'd0);

        for (int r = 0; r < 12; r++) begin
            v = (r % 3 == 0) ? int'($urandom_range(0, 99)) : int'($urandom_range(0, 65535));
            n = int'($urandom_range(1, 5));
            st = int'($urandom_range(0, 31));
            rnd_mode = r[0];
            run_job(v, st, n, "rnd");
        end
        rnd_mode = 1'b0;
        cycles(2);

        start_job(999, 0, 3);
        cycles(VW + 2);
        #2;
        HRESETn = 1'b0;
        #1;
        check("rstmid_trans", {30'd0, M_HTRANS}, 32'd0);
        check("rstmid_addr", M_HADDR, 32'd0);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        ahb_read(2'd2, s1);
        check("rstmid_status", s1, 32'd0);
        run_job(5, 1, 2, "jafter");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
